// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-side register hazard scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Register index map used by the decoder: 0 is $zero / "no register", 1..31
// are GPRs, and indices above 31 are specials (HI/LO, syscall pseudo-sources).
package hazard_pkg;

    // Default register index width produced by the decoder.
    localparam int REG_W_DEFAULT = 6;

    // Storage widths inside a scoreboard entry. Wide enough for any REG_W up
    // to 8 and any DEPTH up to 15; narrower indices are zero-extended.
    localparam int ENT_IDX_W = 8;
    localparam int RDY_W     = 4;

    // Well-known register indices.
    localparam logic [REG_W_DEFAULT-1:0] REG_ZERO      = 6'd0;
    localparam logic [REG_W_DEFAULT-1:0] REG_SYSCALL_A = 6'd2;   // v0 read by syscall
    localparam logic [REG_W_DEFAULT-1:0] REG_SYSCALL_B = 6'd4;   // a0 read by syscall
    localparam logic [REG_W_DEFAULT-1:0] REG_RA        = 6'd31;
    localparam logic [REG_W_DEFAULT-1:0] REG_HILO      = 6'b100001;

    // One in-flight write tracked at a pipeline stage.
    //   valid  : stage holds a real instruction (not a bubble)
    //   wr_idx : destination index, 0 = writes nothing
    //   rdy    : first stage number at which the result can be forwarded
    typedef struct packed {
        logic                 valid;
        logic [ENT_IDX_W-1:0] wr_idx;
        logic [RDY_W-1:0]     rdy;
    } hz_entry_t;

endpackage

// File: rtl/hazard_src_resolve.sv
// Resolves one decode source index against the in-flight write entries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result drives the top-level stall request.
//
// Ports:
//   src     : source register index (zero-extended), 0 never matches
//   entries : scoreboard entries, index k = stage k (1 = EX ... DEPTH = WB)
//   hazard  : youngest matching writer is not yet forwardable
//   fwd_sel : stage to forward from when no hazard, 0 = register file
module hazard_src_resolve
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic [ENT_IDX_W-1:0]   src,
    input  hz_entry_t [DEPTH:1]    entries,
    output logic                   hazard,
    output logic [SEL_W-1:0]       fwd_sel
);

    logic found;

    // Scan from the youngest stage upward; only the first match decides.
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = '0;
        found   = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            // With a write-before-read register file the WB stage value is
            // already visible through the normal read port.
            if (!found && entries[k].valid && (entries[k].wr_idx == src) &&
                (src != '0) && !((RF_BYPASS != 0) && (k == DEPTH))) begin
                found = 1'b1;
                if (k >= int'(entries[k].rdy)) begin
                    fwd_sel = SEL_W'(k);
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Decode-side scoreboard: load-use stall request and per-source forward selects.
// Latency: stall_o/fwd*_o combinational (zero cycles); entries shift on clk.
// Backpressure: stall_o freezes PC/IF/ID and bubbles EX; hold_i freezes all entries.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   id_valid_i        : ID stage holds a real instruction
//   id_rs_i, id_rt_i  : source indices read by the ID instruction
//   id_wr_i           : destination index, 0 = no write
//   id_load_i         : ID instruction is a load
//   hold_i            : global freeze from the memory system (highest priority)
//   flush_i           : kill the ID instruction (branch redirect)
//   stall_o           : hazard on either source, suppressed by flush
//   fwd1_o, fwd2_o    : forward select per source, 0 = register file, k = stage k
//   stall_cnt_o       : saturating count of cycles that actually stalled
module reg_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W      = REG_W_DEFAULT,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int RF_BYPASS  = 1,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_wr_i,
    input  logic             id_load_i,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [SEL_W-1:0] fwd1_o,
    output logic [SEL_W-1:0] fwd2_o,
    output logic [31:0]      stall_cnt_o
);

    hz_entry_t [DEPTH:1] ent_q;
    hz_entry_t           ent_in;
    logic                haz_rs;
    logic                haz_rt;
    logic                bubble;

    hazard_src_resolve #(
        .DEPTH     (DEPTH),
        .RF_BYPASS (RF_BYPASS),
        .SEL_W     (SEL_W)
    ) u_rs (
        .src     (ENT_IDX_W'(id_rs_i)),
        .entries (ent_q),
        .hazard  (haz_rs),
        .fwd_sel (fwd1_o)
    );

    hazard_src_resolve #(
        .DEPTH     (DEPTH),
        .RF_BYPASS (RF_BYPASS),
        .SEL_W     (SEL_W)
    ) u_rt (
        .src     (ENT_IDX_W'(id_rt_i)),
        .entries (ent_q),
        .hazard  (haz_rt),
        .fwd_sel (fwd2_o)
    );

    // A flushed instruction never stalls: the redirect wins.
    assign stall_o = id_valid_i & ~flush_i & (haz_rs | haz_rt);

    // Stalled, flushed or empty ID slots enter EX as bubbles.
    assign bubble = stall_o | flush_i | ~id_valid_i;

    always_comb begin
        ent_in        = '0;
        ent_in.valid  = 1'b1;
        ent_in.wr_idx = ENT_IDX_W'(id_wr_i);
        ent_in.rdy    = id_load_i ? RDY_W'(LOAD_READY) : RDY_W'(ALU_READY);
        if (bubble) begin
            ent_in = '0;
        end
    end

    // Entry k moves to k+1 each unheld cycle; the stage-DEPTH entry retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else if (!hold_i) begin
            for (int k = DEPTH; k >= 2; k--) begin
                ent_q[k] <= ent_q[k-1];
            end
            ent_q[1] <= ent_in;
        end
    end

    // Only stalls that actually cost a pipeline cycle are counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_o && !hold_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule
